bsg_fifo_small_nelem: RTL and testbench

Parametrised multi-entry successor to the single-element FIFO: a `els_p`-deep, `width_p`-wide synchronous FIFO with ready/valid input and valid/yumi output. It sits between producer and consumer pipeline stages wherever one slot of slack is not enough to cover handshake latency. It also reports its occupancy, and the configuration section defines an optional empty-bypass path.

---
 rtl/bsg_fifo_small_nelem.sv | 102 ++++++++++
 tb/tb_bsg_fifo_small_nelem.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/bsg_fifo_small_nelem.sv
// bsg_fifo_small_nelem: els_p-deep, width_p-wide synchronous FIFO.
// Ready/valid on the input side, valid/yumi on the output side, and the
// current occupancy is reported on count_o.
// Optional feature: define BSG_FIFO_SMALL_BYPASS_EN to let an empty FIFO
// present the incoming item on its output in the same cycle (0-cycle latency).
// With the macro undefined there is no combinational input-to-output path.
module bsg_fifo_small_nelem #(
  parameter int width_p = 16,
  parameter int els_p   = 4,
  localparam int lg_els_lp = $clog2(els_p + 1)
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 v_i,
  input  logic [width_p-1:0]   data_i,
  output logic                 ready_o,
  output logic                 v_o,
  output logic [width_p-1:0]   data_o,
  input  logic                 yumi_i,
  output logic [lg_els_lp-1:0] count_o
);

  localparam int ptr_w_lp = $clog2(els_p);
  localparam logic [ptr_w_lp-1:0]  last_ptr_lp = ptr_w_lp'(els_p - 1);
  localparam logic [lg_els_lp-1:0] full_cnt_lp = lg_els_lp'(els_p);

  // Pointers wrap explicitly at els_p-1 so non-power-of-two depths work.
  function automatic logic [ptr_w_lp-1:0] next_ptr(input logic [ptr_w_lp-1:0] p);
    return (p == last_ptr_lp) ? '0 : p + ptr_w_lp'(1);
  endfunction

  logic [width_p-1:0]   mem_q [els_p];
  logic [ptr_w_lp-1:0]  rptr_q, rptr_d;
  logic [ptr_w_lp-1:0]  wptr_q, wptr_d;
  logic [lg_els_lp-1:0] count_q, count_d;

  logic empty, full;
  logic enq, deq;

  assign empty   = (count_q == '0);
  assign full    = (count_q == full_cnt_lp);
  assign ready_o = ~full;
  assign count_o = count_q;

`ifdef BSG_FIFO_SMALL_BYPASS_EN
  logic pass_through;

  // When empty the input is forwarded straight to the output; an item that
  // is consumed on the same cycle never touches the storage.
  assign v_o          = empty ? v_i : 1'b1;
  assign data_o       = empty ? data_i : mem_q[rptr_q];
  assign pass_through = empty & v_i & yumi_i;
  assign enq          = v_i & ready_o & ~pass_through & ~reset_i;
  assign deq          = yumi_i & ~empty & ~reset_i;
`else
  assign v_o    = ~empty;
  assign data_o = mem_q[rptr_q];
  assign enq    = v_i & ready_o & ~reset_i;
  assign deq    = yumi_i & v_o & ~reset_i;
`endif

  // Next-state for pointers and occupancy; reset discards all entries.
  always_comb begin
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    if (reset_i) begin
      rptr_d  = '0;
      wptr_d  = '0;
      count_d = '0;
    end else begin
      if (enq) wptr_d = next_ptr(wptr_q);
      if (deq) rptr_d = next_ptr(rptr_q);
      unique case ({enq, deq})
        2'b10:   count_d = count_q + lg_els_lp'(1);
        2'b01:   count_d = count_q - lg_els_lp'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register.
  always_ff @(posedge clk_i) begin
    rptr_q  <= rptr_d;
    wptr_q  <= wptr_d;
    count_q <= count_d;
  end

  // Storage array; intentionally not reset.
  always_ff @(posedge clk_i) begin
    if (enq) mem_q[wptr_q] <= data_i;
  end

`ifndef SYNTHESIS
  // A yumi with nothing valid on the output is a consumer protocol error.
  always_ff @(posedge clk_i) begin
    if (!reset_i && yumi_i)
      assert (v_o) else $error("bsg_fifo_small_nelem: yumi_i asserted while v_o=0");
  end
`endif

endmodule

// File: tb/tb_bsg_fifo_small_nelem.sv
// Bench for bsg_fifo_small_nelem: a 4-deep and a 3-deep instance, each
// compared every cycle against a queue-based reference model.
module tb_bsg_fifo_small_nelem;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Instance A: els_p = 4
  logic        rst_a = 1'b0, v_a = 1'b0, y_a = 1'b0;
  logic [15:0] d_a = '0;
  logic        rdy_a, vo_a;
  logic [15:0] do_a;
  logic [2:0]  cnt_a;

  // Instance B: els_p = 3
  logic        rst_b = 1'b0, v_b = 1'b0, y_b = 1'b0;
  logic [15:0] d_b = '0;
  logic        rdy_b, vo_b;
  logic [15:0] do_b;
  logic [1:0]  cnt_b;

  bsg_fifo_small_nelem #(.width_p(16), .els_p(4)) dut_a (
    .clk_i(clk), .reset_i(rst_a), .v_i(v_a), .data_i(d_a), .ready_o(rdy_a),
    .v_o(vo_a), .data_o(do_a), .yumi_i(y_a), .count_o(cnt_a));

  bsg_fifo_small_nelem #(.width_p(16), .els_p(3)) dut_b (
    .clk_i(clk), .reset_i(rst_b), .v_i(v_b), .data_i(d_b), .ready_o(rdy_b),
    .v_o(vo_b), .data_o(do_b), .yumi_i(y_b), .count_o(cnt_b));

  logic [15:0] q_a[$];
  logic [15:0] q_b[$];
  bit known_a = 0, known_b = 0;
  bit bypass_en = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock for instance A; yumi is only offered when the model says v_o=1.
  task automatic step_a(input logic rst, input logic v, input logic [15:0] d, input logic y);
    logic er, ev, byp;
    logic [15:0] ed;
    er  = (q_a.size() != 4);
    byp = bypass_en && (q_a.size() == 0);
    ev  = byp ? v : (q_a.size() != 0);
    ed  = byp ? d : ((q_a.size() != 0) ? q_a[0] : 16'h0);
    rst_a = rst; v_a = v; d_a = d; y_a = y & ev;
    @(negedge clk);
    if (known_a) begin
      chk("A.ready", 32'(rdy_a), 32'(er));
      chk("A.v_o",   32'(vo_a),  32'(ev));
      chk("A.count", 32'(cnt_a), 32'(q_a.size()));
      if (ev) chk("A.data", 32'(do_a), 32'(ed));
    end
    @(posedge clk);
    if (rst) begin
      q_a.delete();
      known_a = 1;
    end else if (!(byp && v && y && ev)) begin
      if (y && ev) void'(q_a.pop_front());
      if (v && er) q_a.push_back(d);
    end
    #1;
    rst_a = 1'b0; v_a = 1'b0; y_a = 1'b0;
  endtask

  task automatic step_b(input logic rst, input logic v, input logic [15:0] d, input logic y);
    logic er, ev, byp;
    logic [15:0] ed;
    er  = (q_b.size() != 3);
    byp = bypass_en && (q_b.size() == 0);
    ev  = byp ? v : (q_b.size() != 0);
    ed  = byp ? d : ((q_b.size() != 0) ? q_b[0] : 16'h0);
    rst_b = rst; v_b = v; d_b = d; y_b = y & ev;
    @(negedge clk);
    if (known_b) begin
      chk("B.ready", 32'(rdy_b), 32'(er));
      chk("B.v_o",   32'(vo_b),  32'(ev));
      chk("B.count", 32'(cnt_b), 32'(q_b.size()));
      if (ev) chk("B.data", 32'(do_b), 32'(ed));
    end
    @(posedge clk);
    if (rst) begin
      q_b.delete();
      known_b = 1;
    end else if (!(byp && v && y && ev)) begin
      if (y && ev) void'(q_b.pop_front());
      if (v && er) q_b.push_back(d);
    end
    #1;
    rst_b = 1'b0; v_b = 1'b0; y_b = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
`ifdef BSG_FIFO_SMALL_BYPASS_EN
    bypass_en = 1;
`endif
    @(posedge clk); #1;

    // Reset both instances for two cycles, then idle.
    rst_b = 1'b1;
    step_a(1, 0, 16'h0, 0);
    rst_b = 1'b1;
    step_a(1, 0, 16'h0, 0);
    step_b(1, 0, 16'h0, 0);
    step_b(1, 0, 16'h0, 0);
    step_a(0, 0, 16'h0, 0);
    chk("A.reset.ready", 32'(rdy_a), 32'd1);
    chk("A.reset.v_o",   32'(vo_a),  32'd0);
    chk("A.reset.count", 32'(cnt_a), 32'd0);

    // Fill to full, try a fifth item, then drain.
    for (int i = 1; i <= 5; i++) step_a(0, 1, 16'hA000 + 16'(i), 0);
    for (int i = 0; i < 5; i++)  step_a(0, 0, 16'h0, 1);
    chk("A.drained.v_o", 32'(vo_a), 32'd0);

    // Steady-state simultaneous enqueue/dequeue at count 2, across wraps.
    step_a(0, 1, 16'hB000, 0);
    step_a(0, 1, 16'hB001, 0);
    for (int i = 2; i < 12; i++) step_a(0, 1, 16'hB000 + 16'(i), 1);
    chk("A.steady.count", 32'(cnt_a), 32'd2);

    // Reset mid-operation with count 3 and both handshakes active.
    step_a(0, 1, 16'hC000, 0);
    step_a(1, 1, 16'hC001, 1);
    step_a(0, 0, 16'h0, 0);
    chk("A.midrst.count", 32'(cnt_a), 32'd0);
    chk("A.midrst.v_o",   32'(vo_a),  32'd0);

    // Empty FIFO with v_i and yumi offered together.
    step_a(0, 1, 16'h5A5A, 1);
    step_a(0, 0, 16'h0, 0);
    chk("A.bypass.count", 32'(cnt_a), bypass_en ? 32'd0 : 32'd1);
    step_a(1, 0, 16'h0, 0);

    // Random traffic on the 4-deep instance.
    for (int i = 0; i < 300; i++)
      step_a(0, 1'($urandom), 16'($urandom), 1'($urandom));

    // Non-power-of-two depth: stream items with random yumi.
    for (int i = 0; i < 6; i++) step_b(0, 1, 16'hD000 + 16'(i), 0);
    for (int i = 6; i < 60; i++) step_b(0, 1, 16'hD000 + 16'(i), 1'($urandom));
    for (int i = 0; i < 200; i++)
      step_b(0, 1'($urandom), 16'($urandom), 1'($urandom));
    for (int i = 0; i < 4; i++) step_b(0, 0, 16'h0, 1);
    chk("B.drained.v_o", 32'(vo_b), bypass_en ? 32'd0 : 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
